mdio_phy_responder: RTL

PHY-side MDIO management responder: the target end of the MAC's MDC/MDIO initiator that drives `o_mdc`/`io_md`. It decodes IEEE 802.3 clause-22 frames and answers reads from a small PHY register set. Writes update the writable registers. It sits in simulation and board-emulation builds opposite the Ethmac MDIO master, with the top level resolving `o_md`/`o_md_oe` onto the shared `io_md` wire.

---
 rtl/mdio_pkg.sv | 41 ++++
 rtl/mdio_sync_edge.sv | 33 +++
 rtl/mdio_phy_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// Shared constants for the clause-22 MDIO PHY responder: opcodes, register
// addresses, frame bit positions, FSM encoding and BMCR bit positions.
package mdio_pkg;

   // Clause-22 opcodes as they appear on the wire (b2 is the MSB)
   localparam logic [1:0] MDIO_OP_RD = 2'b10;
   localparam logic [1:0] MDIO_OP_WR = 2'b01;

   // Implemented register addresses
   localparam logic [4:0] MDIO_REG_BMCR   = 5'd0;
   localparam logic [4:0] MDIO_REG_BMSR   = 5'd1;
   localparam logic [4:0] MDIO_REG_PHYID1 = 5'd2;
   localparam logic [4:0] MDIO_REG_PHYID2 = 5'd3;
   localparam logic [4:0] MDIO_REG_ANAR   = 5'd4;

   // Frame bit indices, counted from the first ST bit (b0)
   localparam logic [4:0] MDIO_B_ST1      = 5'd1;
   localparam logic [4:0] MDIO_B_OP1      = 5'd3;
   localparam logic [4:0] MDIO_B_HDR_LAST = 5'd13;
   localparam logic [4:0] MDIO_B_TA0      = 5'd14;
   localparam logic [4:0] MDIO_B_LAST     = 5'd31;

   // Preamble length; the counter saturates here
   localparam logic [5:0] MDIO_PRE_LEN = 6'd32;

   // FSM state encoding
   localparam logic [1:0] ST_PRE  = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_TA   = 2'd2;
   localparam logic [1:0] ST_DATA = 2'd3;

   // BMCR self-clearing reset bit and BMSR preamble-suppression bit
   localparam int MDIO_BMCR_RST_BIT  = 15;
   localparam int MDIO_BMSR_PSUP_BIT = 6;

   // Only read and write are legal clause-22 opcodes
   function automatic logic mdio_op_valid(input logic [1:0] op);
      return (op == MDIO_OP_RD) || (op == MDIO_OP_WR);
   endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchronizer for MDC and MDIO plus a one-cycle MDC rising-edge
// pulse. MDIO is taken from the same synchronizer depth so the sampled data
// bit lines up with the detected edge.
module mdio_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic mdc,
   input  logic md,
   output logic md_sync,
   output logic rise
);

   logic [1:0] mdc_ff;
   logic [1:0] md_ff;
   logic       mdc_prev;

   // Synchronize both lines and remember the previous synchronized MDC
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mdc_ff   <= 2'b00;
         md_ff    <= 2'b00;
         mdc_prev <= 1'b0;
      end else begin
         mdc_ff   <= {mdc_ff[0], mdc};
         md_ff    <= {md_ff[0], md};
         mdc_prev <= mdc_ff[1];
      end
   end

   assign md_sync = md_ff[1];
   assign rise    = mdc_ff[1] & ~mdc_prev;

endmodule

// File: rtl/mdio_phy_responder.sv
// PHY-side clause-22 MDIO responder. Decodes frames from the MAC, answers
// reads from a small register set (BMCR, BMSR, PHYID1/2, ANAR) and stores
// writes to BMCR/ANAR. All protocol actions happen on synchronized MDC
// rising edges.
// Optional build macro: MDIO_PREAMBLE_SUPPRESS_EN -- after a completed frame a
// single preamble 1 is enough before ST, and BMSR bit 6 reads as 1.
module mdio_phy_responder
   import mdio_pkg::*;
#(
   parameter logic [4:0]  P_PHY_ADDR = 5'd1,
   parameter logic [15:0] P_BMCR_RST = 16'h3100,
   parameter logic [15:0] P_BMSR     = 16'h782D,
   parameter logic [15:0] P_PHYID1   = 16'h0022,
   parameter logic [15:0] P_PHYID2   = 16'h1556,
   parameter logic [15:0] P_ANAR_RST = 16'h01E1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_mdc,
   input  logic        i_md,
   output logic        o_md,
   output logic        o_md_oe,
   output logic [15:0] o_bmcr,
   output logic        o_frame_done,
   output logic        o_frame_err
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   localparam logic [15:0] BMSR_READ = P_BMSR | (16'h0001 << MDIO_BMSR_PSUP_BIT);
`else
   localparam logic [15:0] BMSR_READ = P_BMSR;
`endif

   // Synchronized line and edge event
   logic        md_s;
   logic        rise;

   // Frame tracking
   logic [1:0]  state;
   logic [4:0]  bit_idx;
   logic [5:0]  pre_cnt;
   logic [10:0] hdr_sh;      // b2..b12, newest bit in [0]
   logic        is_read;
   logic        addr_match;
   logic [4:0]  reg_sel;
   logic [15:0] rd_sh;       // read data, next bit to drive in [15]
   logic [14:0] wr_sh;       // write data collected so far

   // Register file
   logic [15:0] bmcr;
   logic [15:0] anar;

   // Decode helpers
   logic [4:0]  reg_addr_now;
   logic [4:0]  phy_addr_now;
   logic [1:0]  op_now;
   logic [15:0] wr_value;
   logic [15:0] rd_value;
   logic        pre_start;
   logic        hdr_err;
   logic        frame_end;
   logic        drive;
   logic        short_ok;

   mdio_sync_edge u_sync (
      .clk     (i_clk),
      .reset   (i_reset),
      .mdc     (i_mdc),
      .md      (i_md),
      .md_sync (md_s),
      .rise    (rise)
   );

   assign reg_addr_now = {hdr_sh[3:0], md_s};
   assign phy_addr_now = hdr_sh[8:4];
   assign op_now       = {hdr_sh[0], md_s};
   assign wr_value     = {wr_sh, md_s};
   assign drive        = is_read & addr_match;

   // ST bit 0 is a sampled 0 after a full preamble, or after any 1 when a
   // shortened preamble is currently allowed
   assign pre_start = ~md_s &
                      ((pre_cnt == MDIO_PRE_LEN) | (short_ok & (pre_cnt != 6'd0)));

   assign hdr_err = rise && (state == ST_HDR) &&
                    (((bit_idx == MDIO_B_ST1) && !md_s) ||
                     ((bit_idx == MDIO_B_OP1) && !mdio_op_valid(op_now)));

   assign frame_end = rise && (state == ST_DATA) && (bit_idx == MDIO_B_LAST);

   // Read mux, evaluated with the complete register address on the b13 edge
   always_comb begin
      rd_value = 16'h0000;
      case (reg_addr_now)
         MDIO_REG_BMCR:   rd_value = bmcr;
         MDIO_REG_BMSR:   rd_value = BMSR_READ;
         MDIO_REG_PHYID1: rd_value = P_PHYID1;
         MDIO_REG_PHYID2: rd_value = P_PHYID2;
         MDIO_REG_ANAR:   rd_value = anar;
         default:         rd_value = 16'h0000;
      endcase
   end

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   // Shortened preamble is allowed only right after a completed frame
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         short_ok <= 1'b0;
      end else if (frame_end) begin
         short_ok <= 1'b1;
      end else if (hdr_err) begin
         short_ok <= 1'b0;
      end
   end
`else
   assign short_ok = 1'b0;
`endif

   // Frame FSM, MDIO drive and register updates
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state        <= ST_PRE;
         bit_idx      <= 5'd0;
         pre_cnt      <= 6'd0;
         hdr_sh       <= 11'd0;
         is_read      <= 1'b0;
         addr_match   <= 1'b0;
         reg_sel      <= 5'd0;
         rd_sh        <= 16'h0000;
         wr_sh        <= 15'd0;
         bmcr         <= P_BMCR_RST;
         anar         <= P_ANAR_RST;
         o_md         <= 1'b0;
         o_md_oe      <= 1'b0;
         o_frame_done <= 1'b0;
         o_frame_err  <= 1'b0;
      end else begin
         o_frame_done <= 1'b0;
         o_frame_err  <= 1'b0;
         if (rise) begin
            case (state)
               ST_PRE: begin
                  if (md_s) begin
                     if (pre_cnt != MDIO_PRE_LEN) begin
                        pre_cnt <= pre_cnt + 6'd1;
                     end
                  end else if (pre_start) begin
                     state   <= ST_HDR;
                     bit_idx <= 5'd1;
                     pre_cnt <= 6'd0;
                     hdr_sh  <= 11'd0;
                  end else begin
                     pre_cnt <= 6'd0;
                  end
               end

               ST_HDR: begin
                  // b1 is not kept; the shift register starts filling at b2
                  if (bit_idx != MDIO_B_ST1) begin
                     hdr_sh <= {hdr_sh[9:0], md_s};
                  end
                  bit_idx <= bit_idx + 5'd1;
                  if (hdr_err) begin
                     o_frame_err <= 1'b1;
                     state       <= ST_PRE;
                     bit_idx     <= 5'd0;
                     pre_cnt     <= 6'd0;
                  end else if (bit_idx == MDIO_B_HDR_LAST) begin
                     state      <= ST_TA;
                     is_read    <= (hdr_sh[10:9] == MDIO_OP_RD);
                     addr_match <= (phy_addr_now == P_PHY_ADDR);
                     reg_sel    <= reg_addr_now;
                     rd_sh      <= rd_value;
                  end
               end

               ST_TA: begin
                  bit_idx <= bit_idx + 5'd1;
                  if (bit_idx == MDIO_B_TA0) begin
                     // Second TA bit is driven low by the PHY on reads
                     if (drive) begin
                        o_md_oe <= 1'b1;
                        o_md    <= 1'b0;
                     end
                  end else begin
                     state <= ST_DATA;
                     if (drive) begin
                        o_md <= rd_sh[15];
                     end
                     rd_sh <= {rd_sh[14:0], 1'b0};
                  end
               end

               ST_DATA: begin
                  wr_sh <= {wr_sh[13:0], md_s};
                  if (bit_idx == MDIO_B_LAST) begin
                     o_md_oe      <= 1'b0;
                     o_md         <= 1'b0;
                     o_frame_done <= addr_match;
                     state        <= ST_PRE;
                     bit_idx      <= 5'd0;
                     pre_cnt      <= 6'd0;
                     if (addr_match && !is_read) begin
                        if (reg_sel == MDIO_REG_BMCR) begin
                           // Self-clearing soft reset discards the written value
                           if (wr_value[MDIO_BMCR_RST_BIT]) begin
                              bmcr <= P_BMCR_RST;
                              anar <= P_ANAR_RST;
                           end else begin
                              bmcr <= wr_value;
                           end
                        end else if (reg_sel == MDIO_REG_ANAR) begin
                           anar <= wr_value;
                        end
                     end
                  end else begin
                     bit_idx <= bit_idx + 5'd1;
                     if (drive) begin
                        o_md <= rd_sh[15];
                     end
                     rd_sh <= {rd_sh[14:0], 1'b0};
                  end
               end

               default: begin
                  state   <= ST_PRE;
                  bit_idx <= 5'd0;
                  pre_cnt <= 6'd0;
               end
            endcase
         end
      end
   end

   assign o_bmcr = bmcr;

endmodule
